// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions: field widths, window depth, terminator and FSM states.
package lz77_pkg;

  localparam int unsigned SEARCH_DEPTH = 9;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned OFF_W        = 4;
  localparam int unsigned LEN_W        = 3;
  localparam int unsigned CNT_W        = 12;

  localparam logic [DATA_W-1:0] TERM_CHAR = 8'h24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    LIT  = 2'd2,
    DONE = 2'd3
  } state_e;

  // One LZ77 codeword as carried from the encoder to the decoder.
  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  match_len;
    logic [DATA_W-1:0] char_nxt;
  } codeword_t;

endpackage

// File: rtl/lz77_decoder_if.sv
// Codeword-in / character-out bus of the LZ77 decoder.
//   in_valid/in_ready : codeword handshake (offset, match_len, char_nxt)
//   out_valid/out_char: one decoded character per pulse
//   finish, char_count: sticky end-of-stream flag and emitted-character count
interface lz77_decoder_if;
  import lz77_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OFF_W-1:0]  offset;
  logic [LEN_W-1:0]  match_len;
  logic [DATA_W-1:0] char_nxt;
  logic              out_valid;
  logic [DATA_W-1:0] out_char;
  logic              finish;
  logic [CNT_W-1:0]  char_count;

  // Decoder side.
  modport slave (
    input  in_valid, offset, match_len, char_nxt,
    output in_ready, out_valid, out_char, finish, char_count
  );

  // Codeword source / character sink side.
  modport master (
    output in_valid, offset, match_len, char_nxt,
    input  in_ready, out_valid, out_char, finish, char_count
  );

endinterface

// File: rtl/lz77_hist_buf.sv
// LZ77 history (search) window: a DEPTH-entry shift register, newest at index 0.
//   clk, rst       : clock, asynchronous active-high clear of all entries
//   push_en        : shift history by one and insert push_data at index 0
//   push_data      : character to insert
//   rd_idx         : entry to read (0 = most recent)
//   rd_data_c      : combinational read; 0 when rd_idx >= DEPTH
module lz77_hist_buf
  import lz77_pkg::*;
#(
  parameter int unsigned DEPTH = SEARCH_DEPTH,
  parameter int unsigned W     = DATA_W,
  parameter int unsigned IDX_W = OFF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_en,
  input  logic [W-1:0]     push_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_data_c
);

  logic [W-1:0] hist_q [DEPTH];
  logic [W-1:0] hist_d [DEPTH];

  // Next history: shift toward older entries on push.
  always_comb begin
    hist_d = hist_q;
    if (push_en) begin
      hist_d[0] = push_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        hist_d[i] = hist_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      hist_q <= hist_d;
    end
  end

  // Indexed read; indices past the window fall through to zero.
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (int'(rd_idx) == i) begin
        rd_data_c = hist_q[i];
      end
    end
  end

endmodule

// File: rtl/lz77_decoder.sv
// Streaming LZ77 decoder: turns (offset, match_len, char_nxt) codewords back into
// the original character stream at up to one character per cycle.
//   clk, reset : clock, asynchronous active-high reset
//   dec        : lz77_decoder_if.slave -- codeword handshake in, characters out,
//                sticky finish and a 12-bit wrapping count of emitted characters
module lz77_decoder
  import lz77_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  lz77_decoder_if.slave  dec
);

  state_e            state_q, state_d;
  codeword_t         cw_q, cw_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_char_q, out_char_d;
  logic              finish_q, finish_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              push_en_c;
  logic [DATA_W-1:0] push_data_c;
  logic [DATA_W-1:0] rd_data_c;

  lz77_hist_buf #(
    .DEPTH (SEARCH_DEPTH),
    .W     (DATA_W),
    .IDX_W (OFF_W)
  ) u_hist (
    .clk       (clk),
    .rst       (reset),
    .push_en   (push_en_c),
    .push_data (push_data_c),
    .rd_idx    (cw_q.offset),
    .rd_data_c (rd_data_c)
  );

  // Next-state and output decode. The latched match_len doubles as the
  // remaining-copy counter. Each copied char is pushed as it is emitted, so
  // overlapping matches (offset < match_len) read back their own output.
  always_comb begin
    state_d     = state_q;
    cw_d        = cw_q;
    out_valid_d = 1'b0;
    out_char_d  = out_char_q;
    finish_d    = finish_q;
    push_en_c   = 1'b0;
    push_data_c = rd_data_c;

    unique case (state_q)
      IDLE: begin
        if (dec.in_valid && in_ready_q) begin
          cw_d.offset    = dec.offset;
          cw_d.match_len = dec.match_len;
          cw_d.char_nxt  = dec.char_nxt;
          state_d        = (dec.match_len != '0) ? COPY : LIT;
        end
      end
      COPY: begin
        out_valid_d    = 1'b1;
        out_char_d     = rd_data_c;
        push_en_c      = 1'b1;
        push_data_c    = rd_data_c;
        cw_d.match_len = cw_q.match_len - LEN_W'(1);
        if (cw_q.match_len == LEN_W'(1)) begin
          state_d = LIT;
        end
      end
      LIT: begin
        if (cw_q.char_nxt == TERM_CHAR) begin
          finish_d = 1'b1;
          state_d  = DONE;
        end else begin
          out_valid_d = 1'b1;
          out_char_d  = cw_q.char_nxt;
          push_en_c   = 1'b1;
          push_data_c = cw_q.char_nxt;
          state_d     = IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    cnt_d      = out_valid_d ? (cnt_q + CNT_W'(1)) : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cw_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      finish_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cw_q        <= cw_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      finish_q    <= finish_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dec.in_ready   = in_ready_q;
  assign dec.out_valid  = out_valid_q;
  assign dec.out_char   = out_char_q;
  assign dec.finish     = finish_q;
  assign dec.char_count = cnt_q;

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed and encoded-stream checks for lz77_decoder.
module tb_lz77_decoder;
  import lz77_pkg::*;

  localparam int unsigned N_RAND = 2048;

  logic clk = 1'b0;
  logic reset;

  initial forever #5 clk = ~clk;

  lz77_decoder_if dif ();

  lz77_decoder dut (
    .clk   (clk),
    .reset (reset),
    .dec   (dif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] stream [N_RAND];
  logic [7:0] got_q [$];
  bit         mon_en   = 1'b0;
  bit         fin_seen = 1'b0;
  int         fin_at   = -1;

  // Capture emitted characters and the point where finish first rises.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dif.out_valid) got_q.push_back(dif.out_char);
      if (dif.finish && !fin_seen) begin
        fin_seen = 1'b1;
        fin_at   = got_q.size();
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for in_ready, present a codeword for exactly the accepting edge.
  task automatic send(input int off, input int len, input logic [7:0] ch);
    bit ok = 1'b0;
    int i  = 0;
    while (!ok && i < 64) begin
      @(negedge clk);
      if (dif.in_ready) ok = 1'b1;
      i++;
    end
    if (!ok) begin
      check("send_timeout", 32'd0, 32'd1);
      return;
    end
    dif.offset    = OFF_W'(off);
    dif.match_len = LEN_W'(len);
    dif.char_nxt  = ch;
    dif.in_valid  = 1'b1;
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
  endtask

  // The cycle straight after accept carries no output and no ready.
  task automatic skip_latency(input string tag);
    @(negedge clk);
    check({tag, "_lat_valid"}, 32'(dif.out_valid), 32'd0);
    check({tag, "_lat_ready"}, 32'(dif.in_ready), 32'd0);
  endtask

  task automatic expect_chr(input string tag, input logic [7:0] ch);
    @(negedge clk);
    check({tag, "_valid"}, 32'(dif.out_valid), 32'd1);
    check({tag, "_char"}, 32'(dif.out_char), 32'(ch));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] ref_at(input int i);
    return (i < 0) ? 8'h00 : stream[i];
  endfunction

  initial begin
    int p;
    int best_len;
    int best_off;
    int l;
    int mism;

    reset         = 1'b1;
    dif.in_valid  = 1'b0;
    dif.offset    = '0;
    dif.match_len = '0;
    dif.char_nxt  = '0;

    // Reset values
    @(negedge clk);
    check("rst_ready", 32'(dif.in_ready), 32'd1);
    check("rst_valid", 32'(dif.out_valid), 32'd0);
    check("rst_char", 32'(dif.out_char), 32'd0);
    check("rst_finish", 32'(dif.finish), 32'd0);
    check("rst_count", 32'(dif.char_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single literal
    send(0, 0, 8'h31);
    skip_latency("t1");
    expect_chr("t1_c0", 8'h31);
    check("t1_ready", 32'(dif.in_ready), 32'd1);
    check("t1_count", 32'(dif.char_count), 32'd1);

    // Overlapping copy
    send(0, 3, 8'h32);
    skip_latency("t2");
    expect_chr("t2_c0", 8'h31);
    expect_chr("t2_c1", 8'h31);
    expect_chr("t2_c2", 8'h31);
    expect_chr("t2_c3", 8'h32);
    check("t2_count", 32'(dif.char_count), 32'd5);

    // Terminator with a match in front of it
    send(1, 2, TERM_CHAR);
    skip_latency("t3");
    expect_chr("t3_c0", 8'h31);
    expect_chr("t3_c1", 8'h32);
    @(negedge clk);
    check("t3_finish", 32'(dif.finish), 32'd1);
    check("t3_ready", 32'(dif.in_ready), 32'd0);
    check("t3_valid", 32'(dif.out_valid), 32'd0);
    check("t3_hold_char", 32'(dif.out_char), 32'h32);
    dif.offset    = '0;
    dif.match_len = '0;
    dif.char_nxt  = 8'h41;
    dif.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t3_done_valid%0d", i), 32'(dif.out_valid), 32'd0);
    end
    dif.in_valid = 1'b0;
    check("t3_count", 32'(dif.char_count), 32'd7);
    check("t3_finish_held", 32'(dif.finish), 32'd1);

    // Out-of-range offsets read zeros
    pulse_reset();
    check("t4_rst_finish", 32'(dif.finish), 32'd0);
    check("t4_rst_count", 32'(dif.char_count), 32'd0);
    send(8, 7, 8'h35);
    skip_latency("t4a");
    for (int i = 0; i < 7; i++) expect_chr($sformatf("t4a_c%0d", i), 8'h00);
    expect_chr("t4a_c7", 8'h35);
    send(12, 1, 8'h36);
    skip_latency("t4b");
    expect_chr("t4b_c0", 8'h00);
    expect_chr("t4b_c1", 8'h36);
    check("t4_count", 32'(dif.char_count), 32'd10);

    // Reset in the middle of a copy
    send(0, 5, 8'h37);
    skip_latency("t5");
    expect_chr("t5_c0", 8'h36);
    #2 reset = 1'b1;
    #1;
    check("t5_valid", 32'(dif.out_valid), 32'd0);
    check("t5_count", 32'(dif.char_count), 32'd0);
    check("t5_finish", 32'(dif.finish), 32'd0);
    check("t5_ready", 32'(dif.in_ready), 32'd1);
    check("t5_char", 32'(dif.out_char), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(0, 1, 8'h33);
    skip_latency("t5b");
    expect_chr("t5b_c0", 8'h00);
    expect_chr("t5b_c1", 8'h33);

    // Greedy-encoded random stream over alphabet 0..15
    pulse_reset();
    for (int i = 0; i < int'(N_RAND); i++) stream[i] = 8'($urandom_range(0, 15));
    got_q.delete();
    fin_seen = 1'b0;
    fin_at   = -1;
    mon_en   = 1'b1;
    p = 0;
    while (p < int'(N_RAND)) begin
      best_len = 0;
      best_off = 0;
      for (int off = 0; off < int'(SEARCH_DEPTH); off++) begin
        l = 0;
        while (l < 7 && (p + l) < int'(N_RAND) - 1 && ref_at(p + l - 1 - off) == stream[p + l]) l++;
        if (l > best_len) begin
          best_len = l;
          best_off = off;
        end
      end
      send(best_off, best_len, stream[p + best_len]);
      p += best_len + 1;
    end
    send(0, 0, TERM_CHAR);
    for (int i = 0; i < 200 && !fin_seen; i++) @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    check("t6_finish_seen", 32'(fin_seen), 32'd1);
    check("t6_len", 32'(got_q.size()), 32'(N_RAND));
    check("t6_finish_at", 32'(fin_at), 32'(N_RAND));
    check("t6_count", 32'(dif.char_count), 32'(N_RAND));
    mism = 0;
    for (int i = 0; i < int'(N_RAND) && i < got_q.size(); i++) begin
      if (got_q[i] !== stream[i]) mism++;
    end
    check("t6_mismatches", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
